instr_prefetch_queue: RTL and testbench

- Parametrised instruction prefetcher and queue for the t-dla control path.
- Issues burst read requests for a block of `instr_count` instructions starting at `base_addr` and buffers the returned beats in a first-word-fall-through (FWFT) FIFO.
- Presents instructions to the decode/FSM stage with a valid/ready handshake.
- Sits between the external instruction port and `top_fsm`/`instruction_decode`, replacing the fixed-depth fetcher plus queue pair with configurable width, depth and burst length, plus credit-based refill, flush and completion reporting.

---
 rtl/instr_prefetch_queue_pkg.sv | 28 ++
 rtl/instr_prefetch_queue_sync_fifo_fwft.sv | 64 ++++++
 rtl/instr_prefetch_queue.sv | 162 ++++++++++++++++
 tb/tb_instr_prefetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_prefetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch_queue_pkg : shared state encoding and default sizes   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instr_prefetch_queue_pkg;

  localparam int c_def_instr_width = 64;
  localparam int c_def_depth       = 32;
  localparam int c_def_burst_len   = 8;
  localparam int c_def_addr_width  = 10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_REQ     = 3'd2,
    ST_RECV    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DISCARD = 3'd5
  } state_t;

  // Occupancy counters need to represent the full value n, hence n+1.
  function automatic int f_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_prefetch_queue_sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft : first-word-fall-through FIFO, registered level      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_fwft
  import instr_prefetch_queue_pkg::*;
#(
  parameter int WIDTH = c_def_instr_width,
  parameter int DEPTH = c_def_depth,
  localparam int c_aw    = $clog2(DEPTH),
  localparam int c_lvl_w = f_cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic [WIDTH-1:0]   din,
  input  logic               pop,
  output logic [WIDTH-1:0]   dout,
  output logic               empty,
  output logic               full,
  output logic [c_lvl_w-1:0] level
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_aw:0]      r_wr_ptr;
  logic [c_aw:0]      r_rd_ptr;
  logic [c_lvl_w-1:0] r_level;
  logic               w_push;
  logic               w_pop;

  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is left unreset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[c_aw-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                 (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_prefetch_queue : burst instruction prefetcher with FWFT queue  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int INSTR_WIDTH = c_def_instr_width,
  parameter int DEPTH       = c_def_depth,
  parameter int BURST_LEN   = c_def_burst_len,
  parameter int ADDR_WIDTH  = c_def_addr_width,
  localparam int c_len_w    = f_cnt_width(BURST_LEN),
  localparam int c_lvl_w    = f_cnt_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [ADDR_WIDTH-1:0]  instr_count,
  input  logic                   flush,
  output logic                   fetch_req,
  output logic [ADDR_WIDTH-1:0]  fetch_addr,
  output logic [c_len_w-1:0]     fetch_len,
  input  logic                   fetch_ack,
  input  logic                   in_valid,
  input  logic [INSTR_WIDTH-1:0] in_data,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  input  logic                   out_ready,
  output logic [c_lvl_w-1:0]     level,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_next_addr;
  logic [ADDR_WIDTH-1:0]   r_remaining;
  logic [c_len_w-1:0]      r_beats_left;
  logic                    r_err;
  logic                    r_done;
  logic [c_len_w-1:0]      w_len;
  logic [c_lvl_w-1:0]      w_space;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_beat_taken;
  logic [c_len_w-1:0]      w_beats_rem;
  logic                    w_err_set;
  logic                    w_accept;

  always_comb begin
    if (r_remaining >= ADDR_WIDTH'(BURST_LEN)) w_len = c_len_w'(BURST_LEN);
    else                                        w_len = r_remaining[c_len_w-1:0];
  end

  assign w_space      = c_lvl_w'(DEPTH) - level;
  assign w_accept     = (r_state == ST_REQ) && fetch_ack && !flush;
  assign w_push       = (r_state == ST_RECV) && in_valid && !w_full && !flush;
  assign w_beat_taken = in_valid && (r_beats_left != '0) &&
                        ((r_state == ST_RECV) || (r_state == ST_DISCARD));
  assign w_beats_rem  = w_beat_taken ? (r_beats_left - c_len_w'(1)) : r_beats_left;
  // A beat is only legal while a burst is outstanding and has room to land.
  assign w_err_set    = in_valid && !(((r_state == ST_RECV) && !w_full) ||
                                      (r_state == ST_DISCARD));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (instr_count == '0) ? ST_DRAIN : ST_CHECK;
      end
      ST_CHECK: begin
        if (r_remaining == '0)                  w_state_nxt = ST_DRAIN;
        else if (w_space >= c_lvl_w'(w_len))    w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (fetch_ack) w_state_nxt = ST_RECV;
      end
      ST_RECV: begin
        if (w_beat_taken && (w_beats_rem == '0)) w_state_nxt = ST_CHECK;
      end
      ST_DRAIN: begin
        if (w_empty) w_state_nxt = ST_IDLE;
      end
      ST_DISCARD: begin
        if (w_beats_rem == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      if ((r_state == ST_RECV) && (w_beats_rem != '0)) w_state_nxt = ST_DISCARD;
      else                                             w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    fetch_req  = 1'b0;
    fetch_addr = '0;
    fetch_len  = '0;
    if (r_state == ST_REQ) begin
      fetch_req  = 1'b1;
      fetch_addr = r_next_addr;
      fetch_len  = w_len;
    end
    busy      = (r_state != ST_IDLE);
    out_valid = !w_empty;
    done      = r_done;
    err       = r_err;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_next_addr  <= '0;
      r_remaining  <= '0;
      r_beats_left <= '0;
      r_err        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (r_state == ST_DRAIN) && w_empty && !flush;
      if ((r_state == ST_IDLE) && start && !flush) begin
        r_next_addr <= base_addr;
        r_remaining <= instr_count;
        r_err       <= 1'b0;
      end
      if (w_accept) begin
        r_next_addr  <= r_next_addr + ADDR_WIDTH'(w_len);
        r_remaining  <= r_remaining - ADDR_WIDTH'(w_len);
        r_beats_left <= w_len;
      end else if (w_beat_taken) begin
        r_beats_left <= w_beats_rem;
      end
      if (flush)     r_remaining <= '0;
      if (w_err_set) r_err       <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .push  (w_push),
    .din   (in_data),
    .pop   (out_ready),
    .dout  (out_instr),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_prefetch_queue : directed scoreboard bench for the queue    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_instr_prefetch_queue;

  typedef struct packed {
    logic [9:0] addr;
    logic [3:0] len;
  } req_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  instr_count;
  logic        flush;
  logic        fetch_req;
  logic [9:0]  fetch_addr;
  logic [3:0]  fetch_len;
  logic        fetch_ack;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_instr;
  logic        out_ready;
  logic [5:0]  level;
  logic        busy;
  logic        done;
  logic        err;

  int          n_pass  = 0;
  int          n_total = 0;
  int          n_done  = 0;
  int          n_req   = 0;
  int          n_pops  = 0;
  logic        cons_ready = 1'b0;
  int          m_beats  = 0;
  int          m_budget = -1;
  int          m_seq    = 0;
  bit          m_seen   = 1'b0;
  bit          m_push   = 1'b1;
  logic [9:0]  m_addr   = '0;
  logic [63:0] sb[$];
  req_t        rq[$];

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .INSTR_WIDTH (64),
    .DEPTH       (32),
    .BURST_LEN   (8),
    .ADDR_WIDTH  (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .instr_count (instr_count),
    .flush       (flush),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_len   (fetch_len),
    .fetch_ack   (fetch_ack),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .level       (level),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One cycle: observe at the falling edge, then drive the memory port and consumer.
  task automatic tick();
    req_t exp_r;
    @(negedge clk);
    start     = 1'b0;
    flush     = 1'b0;
    fetch_ack = 1'b0;
    in_valid  = 1'b0;
    out_ready = cons_ready;
    if (done) n_done++;
    if (out_valid && out_ready) begin
      n_pops++;
      if (sb.size() != 0) check("pop_data", out_instr, sb.pop_front());
      else                check("pop_sb_nonempty", 64'(sb.size()), 64'd1);
    end
    if (m_beats != 0 && m_budget != 0) begin
      in_valid = 1'b1;
      in_data  = {16'hBEEF, m_seq[15:0], 22'd0, m_addr};
      if (m_push) sb.push_back(in_data);
      m_seq++;
      m_addr = m_addr + 10'd1;
      m_beats--;
      if (m_budget > 0) m_budget--;
    end else if (fetch_req && m_beats == 0) begin
      if (!m_seen) begin
        m_seen = 1'b1;
        n_req++;
        if (rq.size() != 0) begin
          exp_r = rq.pop_front();
          check("req_addr", 64'(fetch_addr), 64'(exp_r.addr));
          check("req_len", 64'(fetch_len), 64'(exp_r.len));
        end else begin
          check("req_expected", 64'(rq.size()), 64'd1);
        end
      end else begin
        fetch_ack = 1'b1;
        m_beats   = int'(fetch_len);
        m_addr    = fetch_addr;
        m_seen    = 1'b0;
      end
    end
  endtask

  task automatic launch(input logic [9:0] addr, input logic [9:0] cnt);
    start       = 1'b1;
    base_addr   = addr;
    instr_count = cnt;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; instr_count = '0; flush = 1'b0;
    fetch_ack = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_fetch_req", 64'(fetch_req), 64'd0);
    check("rst_fetch_addr_len", 64'({fetch_addr, fetch_len}), 64'd0);
    check("rst_flags", 64'({out_valid, done, busy, err}), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    rst = 1'b1;
    tick();

    // 1: 20 instructions across the address wrap, consumer always ready
    n_done = 0; n_req = 0; n_pops = 0; cons_ready = 1'b1;
    rq.push_back('{10'h3F0, 4'd8});
    rq.push_back('{10'h3F8, 4'd8});
    rq.push_back('{10'h000, 4'd4});
    launch(10'h3F0, 10'd20);
    tick();
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_req_not_yet", 64'(fetch_req), 64'd0);
    tick();
    check("t1_req_t2", 64'(fetch_req), 64'd1);
    for (int i = 0; i < 300 && n_done == 0; i++) tick();
    check("t1_done", 64'(n_done), 64'd1);
    check("t1_pops", 64'(n_pops), 64'd20);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);
    check("t1_req_count", 64'(n_req), 64'd3);
    check("t1_err", 64'(err), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    tick();
    check("t1_done_pulse", 64'(done), 64'd0);

    // 2: empty program
    n_done = 0; n_req = 0;
    launch(10'h055, 10'd0);
    tick();
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_done_early", 64'(done), 64'd0);
    tick();
    check("t2_done", 64'(done), 64'd1);
    check("t2_idle", 64'(busy), 64'd0);
    tick();
    check("t2_done_once", 64'(done), 64'd0);
    check("t2_no_req", 64'(n_req), 64'd0);

    // 3: stalled consumer fills the queue, then credit frees a fifth burst
    n_done = 0; n_req = 0; n_pops = 0; cons_ready = 1'b0;
    for (int k = 0; k < 5; k++) rq.push_back('{10'h010 + 10'(8 * k), 4'd8});
    launch(10'h010, 10'd40);
    for (int i = 0; i < 100 && !(n_req == 4 && level == 6'd32); i++) tick();
    repeat (5) tick();
    check("t3_req4", 64'(n_req), 64'd4);
    check("t3_level_full", 64'(level), 64'd32);
    check("t3_waiting", 64'({busy, fetch_req}), 64'b10);
    cons_ready = 1'b1;
    repeat (8) tick();
    cons_ready = 1'b0;
    for (int i = 0; i < 20 && n_req < 5; i++) tick();
    check("t3_req5", 64'(n_req), 64'd5);
    check("t3_level_after_pops", 64'(level), 64'd24);
    cons_ready = 1'b1;
    for (int i = 0; i < 400 && n_done == 0; i++) tick();
    check("t3_done", 64'(n_done), 64'd1);
    check("t3_pops", 64'(n_pops), 64'd40);
    check("t3_err", 64'(err), 64'd0);

    // 4: flush after 3 of 8 beats
    n_done = 0; n_req = 0; cons_ready = 1'b0; m_budget = 3;
    rq.push_back('{10'h100, 4'd8});
    launch(10'h100, 10'd8);
    for (int i = 0; i < 40 && level != 6'd3; i++) tick();
    check("t4_level3", 64'(level), 64'd3);
    flush = 1'b1;
    sb.delete();
    tick();
    check("t4_level_cleared", 64'(level), 64'd0);
    check("t4_discard_busy", 64'(busy), 64'd1);
    m_budget = 5; m_push = 1'b0;
    repeat (6) tick();
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_err", 64'(err), 64'd0);
    check("t4_level", 64'({out_valid, level}), 64'd0);
    check("t4_no_done", 64'(n_done), 64'd0);
    m_budget = -1; m_push = 1'b1;

    // 5: stray beat in IDLE is sticky until start; flush beats start
    in_valid = 1'b1; in_data = 64'h1234;
    tick();
    check("t5_err_set", 64'(err), 64'd1);
    repeat (3) tick();
    check("t5_err_sticky", 64'(err), 64'd1);
    launch(10'h020, 10'd5);
    flush = 1'b1;
    tick();
    check("t5_flush_wins", 64'({busy, err}), 64'b01);
    launch(10'h020, 10'd0);
    tick();
    check("t5_err_cleared", 64'(err), 64'd0);
    repeat (2) tick();

    // 6: reset mid-burst
    n_req = 0; cons_ready = 1'b0; m_budget = 4;
    rq.push_back('{10'h200, 4'd8});
    launch(10'h200, 10'd8);
    for (int i = 0; i < 40 && level != 6'd4; i++) tick();
    check("t6_level4", 64'(level), 64'd4);
    rst = 1'b0;
    tick();
    check("t6_rst_level", 64'(level), 64'd0);
    check("t6_rst_flags", 64'({fetch_req, out_valid, done, busy, err}), 64'd0);
    rst = 1'b1;
    sb.delete(); m_beats = 0; m_seen = 1'b0; m_budget = -1;
    tick();
    check("t6_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
